// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Shares one sprite ROM between NUM_REQ sprite drawers during the
//   frame-buffer write pass. One requester is granted per cycle, round-robin.
//   The granted address is registered onto rom_addr, and the read is tagged
//   with the requester ID. The word comes back with that ID ROM_LAT+1 cycles
//   after the grant cycle.
//
// Handshake: req[i] is a valid that is held, together with its address,
//   until gnt[i] is seen. gnt is the ready. A request is accepted at the
//   clock edge that ends the cycle in which gnt[i]=1. The return path has no
//   back-pressure: rd_valid is a one-cycle pulse.
//
// Optional feature (macro SPRITE_ARB_STATS_EN): adds conflict_cnt, a
//   saturating count of edges with two or more simultaneous requests. It is
//   cleared by frame_start.
//
// Ports:
//   Clk50        in   system clock
//   Reset_n      in   asynchronous active-low reset
//   frame_start  in   one-cycle pulse, restarts the round-robin pointer at 0
//   req          in   [NUM_REQ]         request per drawer
//   addr         in   [NUM_REQ*ADDR_W]  drawer i address at [i*ADDR_W +: ADDR_W]
//   gnt          out  [NUM_REQ]         one-hot combinational grant
//   rom_addr     out  [ADDR_W]          registered ROM address
//   rom_data     in   [DATA_W]          ROM read data
//   rd_valid     out  returned word valid (one-cycle pulse)
//   rd_id        out  [ID_W]            requester of the returned word
//   rd_data      out  [DATA_W]          returned word (rom_data passthrough)
//   busy         out  any read in flight
//   conflict_cnt out  [16]              conflict counter (SPRITE_ARB_STATS_EN only)
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 2,
    parameter int ID_W    = 3
) (
    input  logic                      Clk50,
    input  logic                      Reset_n,
    input  logic                      frame_start,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      rd_valid,
    output logic [ID_W-1:0]           rd_id,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy
`ifdef SPRITE_ARB_STATS_EN
    ,
    output logic [15:0]               conflict_cnt
`endif
);

    logic [ID_W-1:0]   ptr;
    logic              gnt_any;
    logic [ID_W-1:0]   gnt_idx;
    logic [ADDR_W-1:0] gnt_addr;

    // Tag pipeline: stage 0 is loaded at the grant edge, and stage ROM_LAT
    // lines up with valid rom_data.
    logic [ROM_LAT:0]  tag_v;
    logic [ID_W-1:0]   tag_id [ROM_LAT+1];

    // Cyclic search from ptr. The first pass takes the lowest index >= ptr.
    // If that finds nothing, the second pass takes the lowest index below
    // ptr. Together they give the order ptr, ptr+1, ..., NUM_REQ-1, 0, ...
    always_comb begin
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        gnt_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && Reset_n && req[i] && (ID_W'(i) >= ptr)) begin
                gnt_any  = 1'b1;
                gnt_idx  = ID_W'(i);
                gnt[i]   = 1'b1;
                gnt_addr = addr[i*ADDR_W +: ADDR_W];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && Reset_n && req[i] && (ID_W'(i) < ptr)) begin
                gnt_any  = 1'b1;
                gnt_idx  = ID_W'(i);
                gnt[i]   = 1'b1;
                gnt_addr = addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge Clk50 or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr      <= '0;
            rom_addr <= '0;
            tag_v    <= '0;
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            if (gnt_any) begin
                rom_addr <= gnt_addr;
            end
            // frame_start wins over the grant's pointer advance. The grant
            // itself was already decided with the old pointer.
            if (frame_start) begin
                ptr <= '0;
            end else if (gnt_any) begin
                ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            tag_v     <= {tag_v[ROM_LAT-1:0], gnt_any};
            tag_id[0] <= gnt_idx;
            for (int k = 1; k <= ROM_LAT; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    assign rd_valid = tag_v[ROM_LAT];
    assign rd_id    = tag_id[ROM_LAT];
    assign rd_data  = rom_data;
    assign busy     = |tag_v;

`ifdef SPRITE_ARB_STATS_EN
    logic [15:0] conflict_q;

    always_ff @(posedge Clk50 or negedge Reset_n) begin
        if (!Reset_n) begin
            conflict_q <= '0;
        end else if (frame_start) begin
            conflict_q <= '0;
        end else if (($countones(req) >= 2) && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 4;
    localparam int ROM_LAT = 2;
    localparam int ID_W    = 3;

    logic                      Clk50;
    logic                      Reset_n;
    logic                      frame_start;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_data;
    logic                      rd_valid;
    logic [ID_W-1:0]           rd_id;
    logic [DATA_W-1:0]         rd_data;
    logic                      busy;
`ifdef SPRITE_ARB_STATS_EN
    logic [15:0]               conflict_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    sprite_rom_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .ROM_LAT(ROM_LAT), .ID_W(ID_W)
    ) dut (
        .Clk50(Clk50),
        .Reset_n(Reset_n),
        .frame_start(frame_start),
        .req(req),
        .addr(addr),
        .gnt(gnt),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .rd_valid(rd_valid),
        .rd_id(rd_id),
        .rd_data(rd_data),
        .busy(busy)
`ifdef SPRITE_ARB_STATS_EN
        ,
        .conflict_cnt(conflict_cnt)
`endif
    );

    // Clock / reset block: 10 ns period
    initial Clk50 = 1'b0;
    always #5 Clk50 = ~Clk50;

    // ROM model: two-edge latency, the word is the low nibble of the address
    logic [ADDR_W-1:0] rom_a1;
    always @(posedge Clk50) begin
        rom_a1   <= rom_addr;
        rom_data <= rom_a1[DATA_W-1:0];
    end

    // Move to 1 ns after the next rising edge; inputs are driven and
    // outputs sampled inside the cycle, away from the edge.
    task automatic tick();
        @(posedge Clk50);
        #1;
    endtask

    task automatic test_reset();
        Reset_n     = 1'b0;
        frame_start = 1'b0;
        req         = 4'b1111;
        addr        = '0;
        tick();
        tick();
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        n_cmp++; if (rom_addr !== 18'd0) begin n_bad++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        n_cmp++; if (rd_id !== 3'd0) begin n_bad++; $display("FAIL reset_rd_id got=%0d exp=0", rd_id); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        req = '0;
        #2 Reset_n = 1'b1;
    endtask

    // Single request from drawer 2, then the wrap-around search from ptr=3
    task automatic test_single_and_wrap();
        tick();                                  // cycle T
        req = 4'b0100;
        addr[2*ADDR_W +: ADDR_W] = 18'd207867;
        #1;
        n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
        tick();                                  // T+1
        req = '0;
        #1;
        n_cmp++; if (rom_addr !== 18'd207867) begin n_bad++; $display("FAIL single_rom_addr got=%0d exp=207867", rom_addr); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got=%b exp=1", busy); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_t1 got=%b exp=0", rd_valid); end
        tick();                                  // T+2
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_t2 got=%b exp=0", rd_valid); end
        tick();                                  // T+3
        n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL single_rd_valid got=%b exp=1", rd_valid); end
        n_cmp++; if (rd_id !== 3'd2) begin n_bad++; $display("FAIL single_rd_id got=%0d exp=2", rd_id); end
        n_cmp++; if (rd_data !== 4'd11) begin n_bad++; $display("FAIL single_rd_data got=%0d exp=11", rd_data); end
        tick();                                  // T+4, ptr is 3
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL single_pulse_len got=%b exp=0", rd_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
        req = 4'b0011;
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL wrap_gnt0 got=%b exp=0001", gnt); end
        tick();
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL wrap_gnt1 got=%b exp=0010", gnt); end
        tick();
        req = '0;
        repeat (4) tick();
    endtask

    // All four requesting for 8 cycles from ptr=0
    task automatic test_back_to_back();
        logic [ID_W-1:0] exp_q[$];
        logic [ID_W-1:0] exp_id;
        for (int i = 0; i < NUM_REQ; i++) begin
            addr[i*ADDR_W +: ADDR_W] = 18'(256 * i + i + 5);
        end
        frame_start = 1'b1;                      // forces ptr back to 0
        tick();
        frame_start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            req = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (k < 8) begin
                n_cmp++;
                if (gnt !== 4'(1 << (k % 4))) begin n_bad++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, gnt, 4'(1 << (k % 4))); end
                exp_q.push_back(ID_W'(k % 4));
            end
            n_cmp++;
            if (rd_valid !== ((k >= 3) && (k < 11))) begin
                n_bad++; $display("FAIL rr_rd_valid k=%0d got=%b exp=%b", k, rd_valid, ((k >= 3) && (k < 11)));
            end
            if (rd_valid === 1'b1 && exp_q.size() > 0) begin
                exp_id = exp_q.pop_front();
                n_cmp++; if (rd_id !== exp_id) begin n_bad++; $display("FAIL rr_rd_id k=%0d got=%0d exp=%0d", k, rd_id, exp_id); end
                n_cmp++; if (rd_data !== 4'(exp_id + 5)) begin n_bad++; $display("FAIL rr_rd_data k=%0d got=%0d exp=%0d", k, rd_data, exp_id + 5); end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rr_missing_returns got=%0d exp=0", exp_q.size()); end
    endtask

    // Grant to 1 in the frame_start cycle: still returned, ptr ends at 0
    task automatic test_frame_start();
        tick();                                  // ptr 0 -> grant 0
        req = 4'b0001;
        tick();                                  // cycle B
        req = 4'b0010;
        frame_start = 1'b1;
        #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL fs_gnt got=%b exp=0010", gnt); end
        tick();                                  // cycle C
        frame_start = 1'b0;
        req = 4'b1111;
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL fs_ptr_zero got=%b exp=0001", gnt); end
        tick();                                  // D
        req = '0;
        n_cmp++; if (rd_valid !== 1'b1 || rd_id !== 3'd0) begin n_bad++; $display("FAIL fs_prior_return got=%b/%0d exp=1/0", rd_valid, rd_id); end
        tick();                                  // B+3
        n_cmp++; if (rd_valid !== 1'b1 || rd_id !== 3'd1) begin n_bad++; $display("FAIL fs_return got=%b/%0d exp=1/1", rd_valid, rd_id); end
        tick();                                  // C+3
        n_cmp++; if (rd_valid !== 1'b1 || rd_id !== 3'd0) begin n_bad++; $display("FAIL fs_next_return got=%b/%0d exp=1/0", rd_valid, rd_id); end
        repeat (3) tick();                       // ptr is 1
    endtask

    // Two reads in flight, then an asynchronous reset pulse mid-cycle
    task automatic test_reset_midop();
        tick();
        req = 4'b0110;
        #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL mid_gnt0 got=%b exp=0010", gnt); end
        tick();
        req = 4'b0100;
        #1;
        n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL mid_gnt1 got=%b exp=0100", gnt); end
        tick();
        req = '0;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
        #1 Reset_n = 1'b0;
        req = 4'b1111;
        #1;
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rd_valid got=%b exp=0", rd_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
        n_cmp++; if (rom_addr !== 18'd0) begin n_bad++; $display("FAIL mid_rom_addr got=%0d exp=0", rom_addr); end
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL mid_gnt_gated got=%b exp=0000", gnt); end
        req = '0;
        #1 Reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL mid_ghost k=%0d got=%b exp=0", k, rd_valid); end
        end
    endtask

`ifdef SPRITE_ARB_STATS_EN
    task automatic test_stats();
        Reset_n = 1'b0;
        #2 Reset_n = 1'b1;
        n_cmp++; if (conflict_cnt !== 16'd0) begin n_bad++; $display("FAIL stats_reset got=%0d exp=0", conflict_cnt); end
        tick();
        req = 4'b0111;
        repeat (5) tick();
        req = '0;
        n_cmp++; if (conflict_cnt !== 16'd5) begin n_bad++; $display("FAIL stats_count got=%0d exp=5", conflict_cnt); end
        frame_start = 1'b1;
        req = 4'b0111;                           // clear beats increment
        tick();
        frame_start = 1'b0;
        req = '0;
        n_cmp++; if (conflict_cnt !== 16'd0) begin n_bad++; $display("FAIL stats_clear got=%0d exp=0", conflict_cnt); end
        force dut.conflict_q = 16'hFFFE;
        #1 release dut.conflict_q;
        req = 4'b0111;
        repeat (3) tick();
        req = '0;
        n_cmp++; if (conflict_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL stats_saturate got=%h exp=ffff", conflict_cnt); end
        repeat (4) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_and_wrap();
        test_back_to_back();
        test_frame_start();
        test_reset_midop();
`ifdef SPRITE_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares the single sprite ROM between NUM_REQ sprite drawers (runner, obstacles, clouds, ground, score) during the frame-buffer write pass.
- Each drawer presents an 18-bit ROM address with a request. The arbiter grants one requester per cycle, round-robin, and drives the ROM address.
- It tags each in-flight read and returns ROM data with the requester ID after the fixed ROM latency.
- Sits between the draw_* address generators and the sprite ROM, in the Clk50 domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 18, sprite ROM address width.
- DATA_W, 4, ROM word width (palette index).
- ROM_LAT, 2, ROM read latency in clock edges from rom_addr launch to valid rom_data (1..4).
- ID_W, 3, requester ID width; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- Clk50  in  1  system clock, the only clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of each frame write pass.
- req  in  NUM_REQ  request per requester; held until granted.
- addr  in  NUM_REQ*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W]; held with req.
- gnt  out  NUM_REQ  one-hot grant, combinational; a request is accepted at the edge ending the cycle in which gnt[i]=1.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_data  in  DATA_W  ROM read data.
- rd_valid  out  1  one-cycle pulse: rd_data is valid for rd_id.
- rd_id  out  ID_W  requester index of the returned word.
- rd_data  out  DATA_W  returned ROM word (rom_data passed through).
- busy  out  1  high while any read is in flight.

Behaviour:
- Reset (Reset_n=0, asynchronous): ptr=0, rom_addr=0, tag pipeline cleared, rd_valid=0, rd_id=0, busy=0. gnt is forced to 0 while Reset_n=0.
- Arbitration:
  - gnt selects the first i with req[i]=1, searching cyclically from ptr: ptr, ptr+1, ..., NUM_REQ-1, 0, ...
  - gnt=0 when req=0.
  - At most one bit of gnt is ever high.
- On the edge E0 ending a grant cycle for index g:
  - rom_addr <= addr[g].
  - ptr <= (g+1) mod NUM_REQ; ptr wraps from NUM_REQ-1 to 0.
  - A tag {valid=1, id=g} enters the pipeline.
- No grant: rom_addr holds its value; a tag with valid=0 enters the pipeline.
- Throughput: one grant per cycle, sustained. No bubbles are inserted between back-to-back grants.
- Tag pipeline: ROM_LAT+1 stages. rd_valid and rd_id come from the last stage.
- Return timing: rd_valid=1 in exactly the cycle following edge E0+ROM_LAT. With ROM_LAT=2, a grant in cycle T gives rd_valid in cycle T+3.
- rd_data = rom_data combinationally. It is meaningful only while rd_valid=1.
- busy is the OR of the valid bits in all pipeline stages.
- frame_start:
  - At the next edge, ptr <= 0. This overrides the ptr update from any grant in the same cycle.
  - Any grant in the frame_start cycle still uses the old ptr and is still returned.
  - In-flight reads are unaffected.
- A requester dropping req without a grant is legal and has no effect.
- A requester changing addr while req=1 and not yet granted is a protocol violation; the result is undefined.
- Reset mid-operation: all in-flight tags are discarded. No rd_valid is produced for them after Reset_n rises.
- Fairness: with all requests held continuously, each requester is granted once per NUM_REQ cycles.

Optional Feature:
- Macro: SPRITE_ARB_STATS_EN.
- Defined:
  - Adds output conflict_cnt [15:0].
  - It increments on every edge where popcount(req) >= 2, i.e. at least one requester is stalled.
  - It saturates at 16'hFFFF.
  - It resets to 0 on Reset_n=0 and is cleared to 0 at the edge after frame_start. The clear has priority over the increment.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset, then only req[2]=1 with addr2=18'd207867 in cycle T -> gnt=4'b0100 in T; rom_addr=207867 from T+1; rd_valid=1, rd_id=2 in T+3 (ROM_LAT=2); ptr=3.
- req=4'b1111 held 8 cycles from ptr=0 -> grant order 0,1,2,3,0,1,2,3; rd_valid high 8 consecutive cycles starting 3 cycles after the first grant, with rd_id sequence 0,1,2,3,0,1,2,3.
- ptr=3, req=4'b0011 -> gnt=4'b0001 (wrap search); next cycle gnt=4'b0010.
- Grant to index 1 and frame_start in the same cycle -> that grant is still returned as rd_id=1; ptr=0 afterwards, not 2.
- Two reads in flight, Reset_n pulsed low mid-cycle -> rd_valid, busy, and rom_addr go to 0 immediately; no rd_valid appears after release.
- With SPRITE_ARB_STATS_EN, req=4'b0111 for 5 cycles -> conflict_cnt=5; frame_start pulse -> 0; forced from 16'hFFFE with 3 more conflict cycles -> saturates at 16'hFFFF.
